// File: rtl/chunk_serial_adder.sv
// rtl/chunk_serial_adder.sv - multi-cycle adder that processes CHUNK bits per clock
//
// Purpose: adds two WIDTH-bit operands plus a carry-in over N = WIDTH/CHUNK
//          clock cycles. Operands are latched when start is accepted in IDLE,
//          one chunk is summed per cycle in RUN, and DONE pulses done for one
//          cycle while the registered result is presented.
//
// Optional feature: define SUBTRACT_EN to add port sub; with sub=1 at
//          acceptance the block computes a - b (c_in ignored, c_out=1 means
//          no borrow).
//
// Ports:
//   clk    in   single clock, rising edge
//   rst    in   asynchronous active-high reset
//   start  in   request a new operation (honoured only in IDLE)
//   a, b   in   WIDTH-bit operands
//   c_in   in   carry into bit 0
//   sub    in   subtract select (only with SUBTRACT_EN)
//   busy   out  1 while in RUN or DONE
//   done   out  one-cycle pulse, result valid
//   sum    out  WIDTH-bit registered result
//   c_out  out  carry out of bit WIDTH-1
//   ovf    out  two's-complement overflow

module chunk_serial_adder #(
   parameter int WIDTH = 64,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
`ifdef SUBTRACT_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic             ovf
);

   localparam int N  = WIDTH / CHUNK;
   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             carry_q, carry_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             c_out_q, c_out_d;
   logic             ovf_q, ovf_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic [CHUNK:0]   chunk_sum;
   logic             msb_carry_in;

   // The latched operands are shifted right one chunk per RUN cycle, so the
   // chunk being processed always sits in the low CHUNK bits.
   always_comb begin
      chunk_sum    = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]}
                   + {{CHUNK{1'b0}}, carry_q};
      // Carry into the top bit of the chunk recovered from the sum bit.
      msb_carry_in = a_q[CHUNK-1] ^ b_q[CHUNK-1] ^ chunk_sum[CHUNK-1];

      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      carry_d = carry_q;
      idx_d   = idx_q;
      sum_d   = sum_q;
      c_out_d = c_out_q;
      ovf_d   = ovf_q;
      busy_d  = busy_q;
      done_d  = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               carry_d = c_in;
`ifdef SUBTRACT_EN
               if (sub) begin
                  b_d     = ~b;
                  carry_d = 1'b1;
               end
`endif
               idx_d   = '0;
               state_d = RUN;
               busy_d  = 1'b1;
            end
         end

         RUN: begin
            a_d     = a_q >> CHUNK;
            b_d     = b_q >> CHUNK;
            carry_d = chunk_sum[CHUNK];
            for (int j = 0; j < N; j++) begin
               if (idx_q == IW'(j)) begin
                  sum_d[j*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
               end
            end
            if (idx_q == LAST_IDX) begin
               // Index wraps to 0 rather than stepping past N-1.
               idx_d   = '0;
               state_d = DONE;
               done_d  = 1'b1;
               c_out_d = chunk_sum[CHUNK];
               ovf_d   = msb_carry_in ^ chunk_sum[CHUNK];
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end

         DONE: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end

         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         idx_q   <= '0;
         sum_q   <= '0;
         c_out_q <= 1'b0;
         ovf_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         carry_q <= carry_d;
         idx_q   <= idx_d;
         sum_q   <= sum_d;
         c_out_q <= c_out_d;
         ovf_q   <= ovf_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy  = busy_q;
   assign done  = done_q;
   assign sum   = sum_q;
   assign c_out = c_out_q;
   assign ovf   = ovf_q;

endmodule

// File: tb/tb_chunk_serial_adder.sv
// tb/tb_chunk_serial_adder.sv - self-checking bench for chunk_serial_adder

module tb_chunk_serial_adder;

   localparam int W  = 64;
   localparam int C  = 4;
   localparam int NN = W / C;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [W-1:0]  a = '0, b = '0;
   logic          c_in = 1'b0;
   logic          busy, done, c_out, ovf;
   logic [W-1:0]  sum;

   logic          start2 = 1'b0;
   logic [7:0]    a2 = '0, b2 = '0;
   logic          c_in2 = 1'b0;
   logic          busy2, done2, c_out2, ovf2;
   logic [7:0]    sum2;

`ifdef SUBTRACT_EN
   logic          sub = 1'b0;
   logic          sub2 = 1'b0;
`endif

   always #5 clk = ~clk;

   chunk_serial_adder #(.WIDTH(W), .CHUNK(C)) dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .c_in(c_in),
`ifdef SUBTRACT_EN
      .sub(sub),
`endif
      .busy(busy), .done(done), .sum(sum), .c_out(c_out), .ovf(ovf)
   );

   chunk_serial_adder #(.WIDTH(8), .CHUNK(8)) dut8 (
      .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .c_in(c_in2),
`ifdef SUBTRACT_EN
      .sub(sub2),
`endif
      .busy(busy2), .done(done2), .sum(sum2), .c_out(c_out2), .ovf(ovf2)
   );

   int vectors = 0;
   int miscompares = 0;

   // Behavioural model: an accepted operation keeps busy for N+1 edges, the
   // last of which shows done with the arithmetic result.
   bit           m_busy = 0, m_done = 0;
   int           m_cnt = 0;
   logic [W-1:0] m_sum = '0, p_sum = '0;
   bit           m_cout = 0, m_ovf = 0, p_cout = 0, p_ovf = 0;
   int           edge_no = 0, done_pulses = 0, done_edge = 0;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic model_edge();
      logic [W-1:0] be;
      logic         ci;
      logic [W:0]   full;
      if (!m_busy) begin
         if (start) begin
            be = b;
            ci = c_in;
`ifdef SUBTRACT_EN
            if (sub) begin
               be = ~b;
               ci = 1'b1;
            end
`endif
            full   = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, ci};
            p_sum  = full[W-1:0];
            p_cout = full[W];
            p_ovf  = (a[W-1] == be[W-1]) && (full[W-1] != a[W-1]);
            m_busy = 1;
            m_cnt  = NN;
         end
         m_done = 0;
      end else if (m_cnt > 0) begin
         m_cnt--;
         if (m_cnt == 0) begin
            m_done = 1;
            m_sum  = p_sum;
            m_cout = p_cout;
            m_ovf  = p_ovf;
         end
      end else begin
         m_busy = 0;
         m_done = 0;
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      edge_no++;
      #1;
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      if (done) done_pulses++;
      if (!m_busy || m_done) begin
         chk("sum", sum, m_sum);
         chk("c_out", c_out, m_cout);
         chk("ovf", ovf, m_ovf);
      end
   endtask

   task automatic run_op(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic ci);
      a = ai; b = bi; c_in = ci; start = 1'b1;
      edge_no = 0; done_pulses = 0;
      step();
      start = 1'b0;
      while (!m_done && edge_no < 200) step();
      if (!m_done) chk("timeout", 64'd0, 64'd1);
      done_edge = edge_no;
   endtask

   initial begin
      #3;
      chk("rst_busy", busy, 64'd0);
      chk("rst_done", done, 64'd0);
      chk("rst_sum", sum, 64'd0);
      chk("rst_cout", c_out, 64'd0);
      chk("rst_ovf", ovf, 64'd0);
      chk("rst_busy8", busy2, 64'd0);
      rst = 1'b0;
      step();

      // all-ones + 1
      run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
      chk("r28_sum", sum, 64'd0);
      chk("r28_cout", c_out, 64'd1);
      chk("r28_ovf", ovf, 64'd0);
      chk("r28_latency", 64'(done_edge), 64'd17);
      step();
      chk("r28_pulses", 64'(done_pulses), 64'd1);

      // signed overflow
      run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
      chk("r29_sum", sum, 64'h8000_0000_0000_0000);
      chk("r29_cout", c_out, 64'd0);
      chk("r29_ovf", ovf, 64'd1);
      step();

      // start re-asserted while busy is ignored
      a = 64'd3; b = 64'd4; c_in = 1'b0; start = 1'b1;
      edge_no = 0; done_pulses = 0;
      step();
      start = 1'b0; a = 64'd9; b = 64'd9;
      step();
      start = 1'b1;
      repeat (3) step();
      start = 1'b0;
      while (!m_done && edge_no < 200) step();
      chk("r30_sum", sum, 64'd7);
      chk("r30_busy_in_done", busy, 64'd1);
      step();
      step();
      chk("r30_pulses", 64'(done_pulses), 64'd1);

      // reset mid-run
      a = 64'h1234_5678_9ABC_DEF0; b = 64'h1111_1111_1111_1111; start = 1'b1;
      edge_no = 0; done_pulses = 0;
      step();
      start = 1'b0;
      repeat (5) step();
      #2 rst = 1'b1;
      #1;
      chk("r31_busy", busy, 64'd0);
      chk("r31_sum", sum, 64'd0);
      chk("r31_done", done, 64'd0);
      m_busy = 0; m_done = 0; m_cnt = 0; m_sum = '0; m_cout = 0; m_ovf = 0;
      rst = 1'b0;
      repeat (20) step();
      chk("r31_no_done", 64'(done_pulses), 64'd0);
      run_op(64'd1, 64'd2, 1'b1);
      chk("r31_sum_after", sum, 64'd4);
      step();

      // single-chunk instance
      a2 = 8'h80; b2 = 8'h80; start2 = 1'b1;
      step();
      start2 = 1'b0;
      chk("r32_busy_e1", busy2, 64'd1);
      chk("r32_done_e1", done2, 64'd0);
      step();
      chk("r32_done_e2", done2, 64'd1);
      chk("r32_sum", sum2, 64'd0);
      chk("r32_cout", c_out2, 64'd1);
      chk("r32_ovf", ovf2, 64'd1);
      step();
      chk("r32_idle", busy2, 64'd0);
      chk("r32_done_e3", done2, 64'd0);

`ifdef SUBTRACT_EN
      sub = 1'b1;
      run_op(64'd5, 64'd7, 1'b0);
      chk("r33_sum", sum, 64'hFFFF_FFFF_FFFF_FFFE);
      chk("r33_cout", c_out, 64'd0);
      chk("r33_ovf", ovf, 64'd0);
      sub = 1'b0;
      step();
`endif

      // random traffic, including start pulses while busy
      for (int i = 0; i < 900; i++) begin
         start = ($urandom % 3) == 0;
         a     = {$urandom, $urandom};
         b     = {$urandom, $urandom};
         case ($urandom % 6)
            0: b = ~a;
            1: a = 64'hFFFF_FFFF_FFFF_FFFF;
            2: b = 64'h8000_0000_0000_0000;
            default: ;
         endcase
         c_in = $urandom % 2;
`ifdef SUBTRACT_EN
         sub = $urandom % 2;
`endif
         step();
      end
      start = 1'b0;
      repeat (20) step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/chunk_serial_adder.md
CHUNK_SERIAL_ADDER -- requirements
Module: chunk_serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 64, meaning operand/sum width in bits.
REQ-002 The block SHALL have parameter CHUNK, default 4, meaning bits added per clock cycle; WIDTH SHALL be an integer multiple of CHUNK; N = WIDTH/CHUNK.
REQ-003 The block SHALL have port clk, input, 1 bit, meaning the single clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, meaning reset; it is asynchronous and active-high.
REQ-005 The block SHALL have port start, input, 1 bit, meaning request to begin an addition.
REQ-006 The block SHALL have ports a and b, input, WIDTH bits each, meaning the operands.
REQ-007 The block SHALL have port c_in, input, 1 bit, meaning carry into bit 0.
REQ-008 The block SHALL have port busy, output, 1 bit, meaning an operation is in progress.
REQ-009 The block SHALL have port done, output, 1 bit, meaning a one-cycle pulse that the result is valid.
REQ-010 The block SHALL have port sum, output, WIDTH bits, meaning the registered result.
REQ-011 The block SHALL have port c_out, output, 1 bit, meaning carry out of bit WIDTH-1.
REQ-012 The block SHALL have port ovf, output, 1 bit, meaning two's-complement overflow: carry into MSB XOR carry out of MSB.

Function
REQ-013 The FSM SHALL have states IDLE, RUN and DONE, with reset state IDLE.
REQ-014 In IDLE, start=1 at a rising edge SHALL latch a, b and c_in internally, clear the chunk index to 0, and move to RUN.
REQ-015 In RUN, each edge SHALL add chunk k = a[k*CHUNK +: CHUNK] + b[same] + carry register, write the result to sum[k*CHUNK +: CHUNK], update the carry register, and increment k.
REQ-016 When k = N-1 is processed, the FSM SHALL move to DONE and register c_out and ovf from that chunk.
REQ-017 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-018 busy SHALL be 1 in RUN and DONE and 0 in IDLE.
REQ-019 Latency SHALL be fixed: done is high during the cycle after the (N+1)th rising edge counted from the accepting edge, e.g. N=16 gives done after edge 17.
REQ-020 start SHALL be ignored in RUN and DONE; the latched operands are unaffected by input changes after acceptance.
REQ-021 sum, c_out and ovf SHALL hold their values from DONE until the next accepted start; during RUN, sum bits of unprocessed chunks are unspecified.
REQ-022 With N=1, a single RUN cycle SHALL complete the operation.
REQ-023 The chunk index counter SHALL be max(1, ceil(log2 N)) bits wide and SHALL never exceed N-1.

Reset
REQ-024 rst=1 SHALL immediately force IDLE, busy=0, done=0, sum=0, c_out=0, ovf=0, chunk index 0 and carry register 0, regardless of clk.
REQ-025 Reset asserted mid-RUN SHALL abandon the operation with no done pulse; the first start after rst deasserts is accepted normally.

Configuration
REQ-026 Macro SUBTRACT_EN, when defined, SHALL add input port sub, 1 bit; when sub=1 at acceptance, the block SHALL latch ~b and force the initial carry to 1, so sum = a - b and c_out = 1 means no borrow; c_in is ignored.
REQ-027 Without SUBTRACT_EN, port sub SHALL NOT exist and the block SHALL add only.

Verification
REQ-028 WIDTH=64, CHUNK=4: a=0xFFFF_FFFF_FFFF_FFFF, b=1, c_in=0, start pulse -> sum=0, c_out=1, ovf=0, done exactly once, after edge 17.
REQ-029 WIDTH=64, CHUNK=4: a=0x7FFF_FFFF_FFFF_FFFF, b=1 -> sum=0x8000_0000_0000_0000, c_out=0, ovf=1.
REQ-030 Start accepted with a=3, b=4; start re-asserted with a=9 and b=9 on edges 3-5 -> result sum=7, single done pulse, busy stays high through DONE.
REQ-031 rst pulsed after edge 6 of an operation -> busy=0, sum=0 immediately, no done pulse; next start with a=1, b=2, c_in=1 -> sum=4.
REQ-032 WIDTH=8, CHUNK=8: a=0x80, b=0x80 -> sum=0x00, c_out=1, ovf=1, done after edge 2.
REQ-033 SUBTRACT_EN, WIDTH=64, CHUNK=4: a=5, b=7, sub=1 -> sum=0xFFFF_FFFF_FFFF_FFFE, c_out=0, ovf=0.
